vga_port_arbiter: RTL and testbench
===================================

Name: vga_port_arbiter

Overview:
- Two-requester arbiter that shares the single write/read register-and-framebuffer interface of the vga controller.
- Typical requesters: m0 = CPU bus bridge (control/status register accesses), m1 = pixel pattern/DMA engine (framebuffer streaming).
- Serialises transactions, waits for downstream completion, routes done/error/read data back to the owner.
- Offers round-robin fairness plus a bounded lock for pixel bursts.

Parameters:
ADDR_WIDTH, 17, address width (bit 16 = register space, 0 = framebuffer)
DATA_WIDTH, 32, data width
MAX_BURST, 640, max consecutive locked grants to one requester
TIMEOUT, 255, WAIT cycles before a transaction is aborted with error

Ports:
clk_i  input  1  clock
rst_n_i  input  1  reset, asynchronous, active-low
m0_write_i / m1_write_i  input  1  write request, level, held until done/error
m0_write_address_i / m1_write_address_i  input  ADDR_WIDTH  write address
m0_write_data_i / m1_write_data_i  input  DATA_WIDTH  write data
m0_read_i / m1_read_i  input  1  read request, level, held until done/error
m0_read_address_i / m1_read_address_i  input  ADDR_WIDTH  read address
m0_lock_i / m1_lock_i  input  1  keep grant for the next transaction
m0_write_done_o / m1_write_done_o  output  1  1-cycle write completion pulse
m0_write_error_o / m1_write_error_o  output  1  1-cycle write error pulse
m0_read_done_o / m1_read_done_o  output  1  1-cycle read completion pulse
m0_read_error_o / m1_read_error_o  output  1  1-cycle read error pulse
m0_read_data_o / m1_read_data_o  output  DATA_WIDTH  last read data for this requester
m0_grant_o / m1_grant_o  output  1  requester owns the port
vga_write_o  output  1  write strobe to controller
vga_write_address_o  output  ADDR_WIDTH  write address
vga_write_data_o  output  DATA_WIDTH  write data
vga_write_done_i  input  1  controller write done
vga_write_error_i  input  1  controller write error
vga_read_o  output  1  read strobe to controller
vga_read_address_o  output  ADDR_WIDTH  read address
vga_read_data_i  input  DATA_WIDTH  controller read data
vga_read_done_i  input  1  controller read done
vga_read_error_i  input  1  controller read error

Behaviour:
- Reset: all outputs 0; state IDLE; priority pointer favours m0; burst counter 0; timeout counter 0.
- Reset mid-transaction drops it silently: no done/error pulse afterwards.
- States: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE. All outputs are registered.
- IDLE, owner selection:
  - If the previous owner still has lock_i=1, has a request, and burst count < MAX_BURST, it is re-granted and burst count increments.
  - Otherwise the round-robin winner is chosen (last served = lowest priority) and burst count is set to 1.
  - If neither requester has a request, stay in IDLE.
- IDLE, latching: owner, address, data and type are latched. Write beats read when one requester asserts both.
- ISSUE (exactly 1 cycle, request seen at cycle N -> strobe at N+1):
  - vga_write_o or vga_read_o = 1 with the latched address/data.
  - If a matching done/error is already asserted, go directly to RESPOND; else go to WAIT.
- WAIT:
  - Strobes deasserted; address/data held stable.
  - Only done/error of the matching type is honoured (read_done during a write is ignored).
  - Timeout counter increments each cycle; at TIMEOUT cycles with no response, go to RESPOND with error.
- RESPOND (1 cycle):
  - Owner's done or error pulse is asserted; error wins if done and error were both seen.
  - On read done, vga_read_data_i is captured into the owner's read_data_o and held until that requester's next read done. Read error leaves read_data_o unchanged.
- grant_o: high in ISSUE, WAIT and RESPOND for the owner; never both high.
- Requester protocol: hold the request until its pulse, then change or drop it on the edge ending RESPOND. The arbiter resamples in IDLE, so there is no double issue.
- Requests dropped mid-transaction are illegal; latched values still complete and the pulse is still generated.
- Widths pass through unchanged; counters saturate, never wrap.

Test Plan:
- m0 write addr 0x00010, data 0x00000ABC at cycle N; vga_write_done_i at N+3 -> vga_write_o=1 only at N+1 with those values; m0_write_done_o=1 at N+4; all m1 outputs stay 0.
- Both requesters hold writes continuously, no lock -> grants go m0,m1,m0,m1,…, m0 first after reset.
- MAX_BURST=4, m0_lock_i=1, m1 pending -> four consecutive m0 transactions, then m1 granted.
- m1 write with no downstream response, TIMEOUT=255 -> m1_write_error_o pulse at issue cycle+256; no done pulse.
- m1 read addr 0x10000, vga_read_data_i=0x00000008 with read_done -> m1_read_done_o pulse; m1_read_data_o=0x8 held across a later m0 read.
- Both done and error asserted in the same cycle -> error pulse only.
- rst_n_i low during WAIT -> all outputs 0 immediately; after release, the next m0 request completes normally with no stale pulse.

Source files
------------

// File: rtl/vga_port_arbiter.sv
// Two-requester arbiter sharing the vga controller's single register/framebuffer port.
// Round-robin with bounded lock; one transaction in flight, responses routed back to the owner.
module vga_port_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 640,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_write_address_i,
  input  logic [DATA_WIDTH-1:0] m0_write_data_i,
  input  logic                  m0_read_i,
  input  logic [ADDR_WIDTH-1:0] m0_read_address_i,
  input  logic                  m0_lock_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_write_address_i,
  input  logic [DATA_WIDTH-1:0] m1_write_data_i,
  input  logic                  m1_read_i,
  input  logic [ADDR_WIDTH-1:0] m1_read_address_i,
  input  logic                  m1_lock_i,
  output logic                  m0_write_done_o,
  output logic                  m0_write_error_o,
  output logic                  m0_read_done_o,
  output logic                  m0_read_error_o,
  output logic [DATA_WIDTH-1:0] m0_read_data_o,
  output logic                  m0_grant_o,
  output logic                  m1_write_done_o,
  output logic                  m1_write_error_o,
  output logic                  m1_read_done_o,
  output logic                  m1_read_error_o,
  output logic [DATA_WIDTH-1:0] m1_read_data_o,
  output logic                  m1_grant_o,
  output logic                  vga_write_o,
  output logic [ADDR_WIDTH-1:0] vga_write_address_o,
  output logic [DATA_WIDTH-1:0] vga_write_data_o,
  input  logic                  vga_write_done_i,
  input  logic                  vga_write_error_i,
  output logic                  vga_read_o,
  output logic [ADDR_WIDTH-1:0] vga_read_address_o,
  input  logic [DATA_WIDTH-1:0] vga_read_data_i,
  input  logic                  vga_read_done_i,
  input  logic                  vga_read_error_i
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                state, state_nxt;
  logic                  owner, owner_nxt;
  logic                  is_wr, is_wr_nxt;
  logic [BW-1:0]         burst, burst_nxt;
  logic [TW-1:0]         tmo, tmo_nxt;
  logic                  rsp_err, rsp_cap;
  logic [1:0]            req_w, req_r, req, lock;
  logic                  hit_done, hit_err, lock_hold;
  logic                  enter_issue, enter_rsp;
  logic [ADDR_WIDTH-1:0] sel_waddr, sel_raddr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign req_w = {m1_write_i, m0_write_i};
  assign req_r = {m1_read_i, m0_read_i};
  assign req   = req_w | req_r;
  assign lock  = {m1_lock_i, m0_lock_i};

  // Only the response matching the in-flight transaction type counts.
  assign hit_done = is_wr ? vga_write_done_i  : vga_read_done_i;
  assign hit_err  = is_wr ? vga_write_error_i : vga_read_error_i;

  // owner doubles as "last served"; burst==0 means nobody has been served since reset.
  assign lock_hold = (burst != '0) && lock[owner] && req[owner] && (burst < BW'(MAX_BURST));

  assign sel_waddr = owner_nxt ? m1_write_address_i : m0_write_address_i;
  assign sel_wdata = owner_nxt ? m1_write_data_i    : m0_write_data_i;
  assign sel_raddr = owner_nxt ? m1_read_address_i  : m0_read_address_i;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    is_wr_nxt = is_wr;
    burst_nxt = burst;
    tmo_nxt   = tmo;
    rsp_err   = 1'b0;
    rsp_cap   = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = ISSUE;
          if (lock_hold) begin
            burst_nxt = burst + 1'b1;
          end else begin
            owner_nxt = (req == 2'b11) ? ~owner : req[1];
            burst_nxt = BW'(1);
          end
          is_wr_nxt = req_w[owner_nxt];
        end
      end
      ISSUE, WAIT: begin
        if (state == ISSUE) tmo_nxt = '0;
        if (hit_done || hit_err) begin
          state_nxt = RESPOND;
          rsp_err   = hit_err;
          rsp_cap   = !is_wr && !hit_err;
        end else if (state == ISSUE) begin
          state_nxt = WAIT;
        end else begin
          if (tmo != TW'(TIMEOUT)) tmo_nxt = tmo + 1'b1;
          if (tmo >= TW'(TIMEOUT - 1)) begin
            state_nxt = RESPOND;
            rsp_err   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      owner <= 1'b1;
      is_wr <= 1'b0;
      burst <= '0;
      tmo   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      is_wr <= is_wr_nxt;
      burst <= burst_nxt;
      tmo   <= tmo_nxt;
    end
  end

  assign enter_issue = (state == IDLE) && (state_nxt == ISSUE);
  assign enter_rsp   = (state_nxt == RESPOND);

  // Every output is a flop loaded from the next-state decode.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vga_write_o         <= 1'b0;
      vga_read_o          <= 1'b0;
      vga_write_address_o <= '0;
      vga_write_data_o    <= '0;
      vga_read_address_o  <= '0;
      m0_grant_o          <= 1'b0;
      m1_grant_o          <= 1'b0;
      m0_write_done_o     <= 1'b0;
      m0_write_error_o    <= 1'b0;
      m0_read_done_o      <= 1'b0;
      m0_read_error_o     <= 1'b0;
      m1_write_done_o     <= 1'b0;
      m1_write_error_o    <= 1'b0;
      m1_read_done_o      <= 1'b0;
      m1_read_error_o     <= 1'b0;
      m0_read_data_o      <= '0;
      m1_read_data_o      <= '0;
    end else begin
      vga_write_o <= enter_issue && is_wr_nxt;
      vga_read_o  <= enter_issue && !is_wr_nxt;
      if (enter_issue) begin
        if (is_wr_nxt) begin
          vga_write_address_o <= sel_waddr;
          vga_write_data_o    <= sel_wdata;
        end else begin
          vga_read_address_o  <= sel_raddr;
        end
      end
      m0_grant_o       <= (state_nxt != IDLE) && !owner_nxt;
      m1_grant_o       <= (state_nxt != IDLE) && owner_nxt;
      m0_write_done_o  <= enter_rsp && !owner && is_wr  && !rsp_err;
      m0_write_error_o <= enter_rsp && !owner && is_wr  && rsp_err;
      m0_read_done_o   <= enter_rsp && !owner && !is_wr && !rsp_err;
      m0_read_error_o  <= enter_rsp && !owner && !is_wr && rsp_err;
      m1_write_done_o  <= enter_rsp && owner  && is_wr  && !rsp_err;
      m1_write_error_o <= enter_rsp && owner  && is_wr  && rsp_err;
      m1_read_done_o   <= enter_rsp && owner  && !is_wr && !rsp_err;
      m1_read_error_o  <= enter_rsp && owner  && !is_wr && rsp_err;
      if (enter_rsp && rsp_cap && !owner) m0_read_data_o <= vga_read_data_i;
      if (enter_rsp && rsp_cap && owner)  m1_read_data_o <= vga_read_data_i;
    end
  end

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Scoreboard bench for vga_port_arbiter: directed scenarios then randomized two-master traffic
// against a downstream responder that decides each response and predicts the resulting pulse.
module tb_vga_port_arbiter;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    wr, rd, lk;
  logic [AW-1:0] wa [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] wd [2];
  wire  [1:0]    wdone, werr, rdone, rerr, gnt;
  wire  [DW-1:0] rdat [2];
  wire           vw, vr;
  wire  [AW-1:0] vwa, vra;
  wire  [DW-1:0] vwd;
  logic [DW-1:0] vrd;
  logic          vwdone, vwerr, vrdone, vrerr;

  vga_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_write_i(wr[0]), .m0_write_address_i(wa[0]), .m0_write_data_i(wd[0]),
    .m0_read_i(rd[0]), .m0_read_address_i(ra[0]), .m0_lock_i(lk[0]),
    .m1_write_i(wr[1]), .m1_write_address_i(wa[1]), .m1_write_data_i(wd[1]),
    .m1_read_i(rd[1]), .m1_read_address_i(ra[1]), .m1_lock_i(lk[1]),
    .m0_write_done_o(wdone[0]), .m0_write_error_o(werr[0]),
    .m0_read_done_o(rdone[0]), .m0_read_error_o(rerr[0]),
    .m0_read_data_o(rdat[0]), .m0_grant_o(gnt[0]),
    .m1_write_done_o(wdone[1]), .m1_write_error_o(werr[1]),
    .m1_read_done_o(rdone[1]), .m1_read_error_o(rerr[1]),
    .m1_read_data_o(rdat[1]), .m1_grant_o(gnt[1]),
    .vga_write_o(vw), .vga_write_address_o(vwa), .vga_write_data_o(vwd),
    .vga_write_done_i(vwdone), .vga_write_error_i(vwerr),
    .vga_read_o(vr), .vga_read_address_o(vra), .vga_read_data_i(vrd),
    .vga_read_done_i(vrdone), .vga_read_error_i(vrerr)
  );

  wire [159:0] all_out = 160'({wdone, werr, rdone, rerr, gnt, rdat[0], rdat[1], vw, vr, vwa, vwd, vra});

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Request levels as the arbiter saw them at the most recent rising edge.
  logic [1:0]    s_wr, s_rd, s_lk;
  logic [AW-1:0] s_wa [2];
  logic [AW-1:0] s_ra [2];
  logic [DW-1:0] s_wd [2];
  always @(posedge clk) begin
    s_wr <= wr; s_rd <= rd; s_lk <= lk;
    s_wa[0] <= wa[0]; s_wa[1] <= wa[1];
    s_ra[0] <= ra[0]; s_ra[1] <= ra[1];
    s_wd[0] <= wd[0]; s_wd[1] <= wd[1];
  end

  typedef struct {
    int            id;
    bit            wrt;
    bit            err;
    logic [DW-1:0] dat;
    longint        at;
  } exp_t;
  exp_t          sb[$];
  int            own_log[$];
  int            m_last;
  int            m_burst;
  logic [DW-1:0] m_rdat [2];

  bit            f_on;
  int            f_kind, f_d;
  logic [DW-1:0] f_dat;

  function automatic void check(input string name, input bit ok, input logic [63:0] act,
                                input logic [63:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void clear_models();
    sb.delete();
    m_last    = 1;
    m_burst   = 0;
    m_rdat[0] = '0;
    m_rdat[1] = '0;
  endfunction

  // Arbitration rules, response decision and expected pulse for one strobe.
  task automatic handle_strobe();
    int            own, d, kind;
    bit            noise, w, off_checked;
    bit [1:0]      rq;
    logic [DW-1:0] rdv;
    exp_t          e;
    rq = s_wr | s_rd;
    if (m_burst != 0 && s_lk[m_last] && rq[m_last] && m_burst < MB) begin
      own = m_last;
      m_burst++;
    end else begin
      own     = (rq == 2'b11) ? 1 - m_last : (rq[0] ? 0 : 1);
      m_burst = 1;
    end
    m_last = own;
    w = s_wr[own];
    check("strobe", {vw, vr, gnt, (vw ? vwa : vra), (vw ? vwd : 32'h0)} ==
                    {w, !w, 2'(1 << own), (w ? s_wa[own] : s_ra[own]), (w ? s_wd[own] : 32'h0)},
          64'({vw, vr, gnt, (vw ? vwa : vra), (vw ? vwd : 32'h0)}),
          64'({w, !w, 2'(1 << own), (w ? s_wa[own] : s_ra[own]), (w ? s_wd[own] : 32'h0)}));
    own_log.push_back(gnt[1] ? 1 : 0);
    if (f_on) begin
      kind = f_kind; d = f_d; rdv = f_dat; noise = 1'b0;
    end else begin
      case ($urandom_range(0, 15))
        0:       kind = 3;
        1, 2:    kind = 1;
        3:       kind = 2;
        default: kind = 0;
      endcase
      d = $urandom_range(0, 4); rdv = $urandom; noise = $urandom_range(0, 1) == 1;
    end
    e.id = own; e.wrt = w; e.err = (kind != 0); e.dat = rdv;
    e.at = cyc + ((kind == 3) ? TO + 1 : d + 1);
    sb.push_back(e);
    off_checked = 1'b0;
    if (kind == 3) begin
      @(negedge clk);
      check("strobe_one_cycle", !(vw || vr), 64'({vw, vr}), 64'(0));
      return;
    end
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      if (!rst_n) return;
      vwdone = 1'b0; vrdone = 1'b0;
      if (i == 1) begin
        check("strobe_one_cycle", !(vw || vr), 64'({vw, vr}), 64'(0));
        off_checked = 1'b1;
        if (noise && d >= 2) begin
          if (w) vrdone = 1'b1; else vwdone = 1'b1;
        end
      end
    end
    if (w) begin
      vwdone = (kind != 1); vwerr = (kind != 0);
    end else begin
      vrdone = (kind != 1); vrerr = (kind != 0); vrd = rdv;
    end
    @(negedge clk);
    vwdone = 1'b0; vwerr = 1'b0; vrdone = 1'b0; vrerr = 1'b0; vrd = $urandom;
    if (!off_checked) check("strobe_one_cycle", !(vw || vr), 64'({vw, vr}), 64'(0));
  endtask

  initial begin : responder
    vwdone = 1'b0; vwerr = 1'b0; vrdone = 1'b0; vrerr = 1'b0; vrd = $urandom;
    forever begin
      @(negedge clk);
      if (rst_n && (vw || vr)) handle_strobe();
    end
  end

  // Monitor: every pulse must match the oldest outstanding expectation.
  task automatic check_pulse(input int id);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_pulse", 1'b0, 64'({wdone[id], werr[id], rdone[id], rerr[id]}), 64'(0));
      return;
    end
    e = sb.pop_front();
    check("pulse", {32'(cyc), 16'(id), wdone[id], werr[id], rdone[id], rerr[id], gnt} ==
                   {32'(e.at), 16'(e.id), e.wrt & !e.err, e.wrt & e.err, !e.wrt & !e.err,
                    !e.wrt & e.err, 2'(1 << e.id)},
          {32'(cyc), 16'(id), 6'b0, wdone[id], werr[id], rdone[id], rerr[id], gnt},
          {32'(e.at), 16'(e.id), 6'b0, e.wrt & !e.err, e.wrt & e.err, !e.wrt & !e.err,
           !e.wrt & e.err, 2'(1 << e.id)});
    if (!e.wrt && !e.err) m_rdat[e.id] = e.dat;
    check("read_data", {rdat[0], rdat[1]} == {m_rdat[0], m_rdat[1]},
          {rdat[0], rdat[1]}, {m_rdat[0], m_rdat[1]});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int id = 0; id < 2; id++)
        if (wdone[id] || werr[id] || rdone[id] || rerr[id]) check_pulse(id);
    end
  end

  task automatic req_txn(input int id, input bit w, input bit r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit l, input bit keep);
    int n;
    wr[id] = w; rd[id] = r; wa[id] = a; ra[id] = a; wd[id] = d; lk[id] = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wdone[id] || werr[id] || rdone[id] || rerr[id]) && n < 700);
    if (n >= 700) check("pulse_wait", 1'b0, 64'(n), 64'(700));
    if (!keep) begin
      wr[id] = 1'b0; rd[id] = 1'b0; lk[id] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr = '0; rd = '0; lk = '0;
    clear_models();
    own_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_master(input int id, input int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(1, 3);
      req_txn(id, op[0], op[1], AW'($urandom), $urandom, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1);
      if (!wr[id] && !rd[id]) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wr[id] = 1'b0; rd[id] = 1'b0; lk[id] = 1'b0;
  endtask

  int exp_rr [6] = '{0, 1, 0, 1, 0, 1};
  int exp_bu [5] = '{0, 0, 0, 0, 1};

  initial begin : main
    int n;
    rst_n = 1'b1;
    wr = '0; rd = '0; lk = '0;
    for (int i = 0; i < 2; i++) begin wa[i] = '0; ra[i] = '0; wd[i] = '0; end
    clear_models();
    f_on = 1'b1; f_kind = 0; f_d = 2; f_dat = '0;
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", all_out == '0, 64'(all_out), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single m0 write, controller answers two cycles after the strobe.
    f_kind = 0; f_d = 2;
    req_txn(0, 1'b1, 1'b0, 17'h00010, 32'h00000ABC, 1'b0, 1'b0);

    // Both masters stream writes without lock: strict alternation, m0 first.
    do_reset();
    f_d = 1;
    fork
      for (int i = 0; i < 3; i++) req_txn(0, 1'b1, 1'b0, 17'h00100 + 17'(i), 32'h100 + i, 1'b0, i < 2);
      for (int i = 0; i < 3; i++) req_txn(1, 1'b1, 1'b0, 17'h00200 + 17'(i), 32'h200 + i, 1'b0, i < 2);
    join
    for (int i = 0; i < 6; i++)
      check("rr_order", own_log.size() > i && own_log[i] == exp_rr[i],
            64'(own_log.size() > i ? own_log[i] : -1), 64'(exp_rr[i]));

    // Locked m0 burst is capped at MAX_BURST grants, then m1 gets in.
    do_reset();
    fork
      for (int i = 0; i < 5; i++) req_txn(0, 1'b1, 1'b0, 17'h00300 + 17'(i), 32'h300 + i, 1'b1, i < 4);
      req_txn(1, 1'b1, 1'b0, 17'h00400, 32'h400, 1'b0, 1'b0);
    join
    for (int i = 0; i < 5; i++)
      check("burst_order", own_log.size() > i && own_log[i] == exp_bu[i],
            64'(own_log.size() > i ? own_log[i] : -1), 64'(exp_bu[i]));

    // Silent controller: timeout error.
    f_kind = 3;
    req_txn(1, 1'b1, 1'b0, 17'h00500, 32'hDEAD, 1'b0, 1'b0);

    // m1 register read, then an m0 read must not disturb m1's data.
    f_kind = 0; f_d = 1; f_dat = 32'h00000008;
    req_txn(1, 1'b0, 1'b1, 17'h10000, 32'h0, 1'b0, 1'b0);
    f_dat = 32'h00000055;
    req_txn(0, 1'b0, 1'b1, 17'h00040, 32'h0, 1'b0, 1'b0);
    check("m1_read_hold", rdat[1] == 32'h8, 64'(rdat[1]), 64'h8);

    // Done and error together: error only.
    f_kind = 2; f_d = 1;
    req_txn(0, 1'b1, 1'b0, 17'h00600, 32'h600, 1'b0, 1'b0);

    // Reset while waiting on the controller drops the transaction silently.
    f_kind = 3;
    wr[0] = 1'b1; rd[0] = 1'b0; wa[0] = 17'h00020; wd[0] = 32'h1234; lk[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!vw && n < 20);
    if (n >= 20) check("strobe_wait", 1'b0, 64'(n), 64'(20));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check("reset_in_wait", all_out == '0, 64'(all_out), 64'(0));
    wr = '0; rd = '0; lk = '0;
    clear_models();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    f_kind = 0; f_d = 1;
    req_txn(0, 1'b1, 1'b0, 17'h00024, 32'h5678, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    check("no_stale", sb.size() == 0, 64'(sb.size()), 64'(0));

    // Randomized traffic with random responses, delays and wrong-type noise.
    f_on = 1'b0;
    fork
      rand_master(0, 60);
      rand_master(1, 60);
    join
    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size() == 0, 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "time limit");
  end

endmodule
